prog_mem_loader: RTL and testbench

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

---
 rtl/prog_mem_loader.sv | 109 ++++++++++
 tb/tb_prog_mem_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// Program memory loader: assembles little-endian bytes from a serial receiver into
// instruction words, stores them, and serves registered instruction fetches.
module prog_mem_loader #(
  parameter int               DATA_W = 32,
  parameter int               DEPTH  = 1024,
  parameter logic [DATA_W-1:0] NOP   = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_byte,
  input  logic                        load_end,
  input  logic                        rd_en,
  input  logic [31:0]                 rd_addr,
  output logic [DATA_W-1:0]           instruction,
  output logic                        rd_valid,
  output logic                        loading,
  output logic                        load_done,
  output logic                        load_err,
  output logic [$clog2(DEPTH+1)-1:0]  word_count
);

  localparam int LANES = DATA_W / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SHIFT = $clog2(LANES);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_next;
  logic [LW-1:0]     lane, lane_after;
  logic [DATA_W-1:0] asm_word, assembled;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              take_byte, full, accept, last_lane, partial_end;
  logic [31:0]       index;
  logic              rd_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start)                         state_next = LOAD;
    else if (state == LOAD && load_end) state_next = DONE;
  end

  always_comb begin
    loading   = (state == LOAD);
    load_done = (state == DONE);
  end

  // start wins over everything else in its cycle, so a coincident byte is dropped
  always_comb begin
    take_byte  = (state == LOAD) && !start && rx_valid;
    full       = (word_count == CW'(DEPTH));
    accept     = take_byte && !full;
    last_lane  = (lane == LW'(LANES - 1));
    assembled  = asm_word;
    assembled[{lane, 3'b000} +: 8] = rx_byte;
    lane_after = lane;
    if (accept) lane_after = last_lane ? '0 : lane + LW'(1);
    partial_end = (state == LOAD) && !start && load_end && (lane_after != '0);
  end

  always_comb begin
    index  = rd_addr >> SHIFT;
    rd_hit = (state != LOAD) && (index < 32'(word_count)) && (index < 32'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count  <= '0;
      lane        <= '0;
      asm_word    <= '0;
      load_err    <= 1'b0;
      instruction <= NOP;
      rd_valid    <= 1'b0;
    end else begin
      if (start) begin
        word_count <= '0;
        lane       <= '0;
        load_err   <= 1'b0;
      end else if (state == LOAD) begin
        if (take_byte && full) load_err <= 1'b1;
        if (accept) begin
          asm_word <= assembled;
          lane     <= lane_after;
          if (last_lane) word_count <= word_count + CW'(1);
        end
        // a load ending mid-word throws the fragment away
        if (partial_end) begin
          lane     <= '0;
          load_err <= 1'b1;
        end
      end
      rd_valid <= rd_en;
      if (rd_en) instruction <= rd_hit ? mem[index[AW-1:0]] : NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && last_lane) mem[word_count[AW-1:0]] <= assembled;
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader (DEPTH=4, 32-bit words, NOP=0).
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        load_end = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] instruction;
  logic        rd_valid, loading, load_done, load_err;
  logic [2:0]  word_count;

  int vectors = 0;
  int miscompares = 0;

  prog_mem_loader #(.DATA_W(32), .DEPTH(4), .NOP(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .load_end(load_end), .rd_en(rd_en), .rd_addr(rd_addr), .instruction(instruction),
    .rd_valid(rd_valid), .loading(loading), .load_done(load_done), .load_err(load_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1; cycle(); load_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b; cycle(); rx_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    rd_en = 1'b1; rd_addr = a; cycle(); rd_en = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (loading !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0 || word_count !== 3'd0 || rd_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_flags: got ld=%b dn=%b er=%b wc=%0d rv=%b, want all 0", loading, load_done, load_err, word_count, rd_valid); end
    #9 rst_n = 1'b1;
    cycle();
    do_read(32'h0);
    vectors++; if (instruction !== 32'h0 || rd_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_read: got %h rv=%b, want 00000000 rv=1", instruction, rd_valid); end
    cycle();
    vectors++; if (rd_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL idle_rd_valid: got %b, want 0", rd_valid); end
  endtask

  task automatic test_load_two();
    logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    pulse_start();
    vectors++; if (loading !== 1'b1 || word_count !== 3'd0) begin
      miscompares++; $display("[TB] FAIL start_enters_load: got ld=%b wc=%0d, want ld=1 wc=0", loading, word_count); end
    foreach (bytes[i]) send_byte(bytes[i]);
    pulse_end();
    vectors++; if (word_count !== 3'd2 || load_done !== 1'b1 || load_err !== 1'b0 || loading !== 1'b0) begin
      miscompares++; $display("[TB] FAIL two_word_status: got wc=%0d dn=%b er=%b ld=%b, want 2 1 0 0", word_count, load_done, load_err, loading); end
    do_read(32'h0);
    vectors++; if (instruction !== 32'h00500013 || rd_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL read_0x0: got %h rv=%b, want 00500013 rv=1", instruction, rd_valid); end
    do_read(32'h5);
    vectors++; if (instruction !== 32'h00100093) begin
      miscompares++; $display("[TB] FAIL read_0x5: got %h, want 00100093", instruction); end
    cycle();
    vectors++; if (instruction !== 32'h00100093 || rd_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL hold_value: got %h rv=%b, want 00100093 rv=0", instruction, rd_valid); end
    do_read(32'h8);
    vectors++; if (instruction !== 32'h0) begin
      miscompares++; $display("[TB] FAIL read_0x8_nop: got %h, want 00000000", instruction); end
  endtask

  task automatic test_partial();
    pulse_start();
    for (int i = 1; i <= 5; i++) send_byte(8'(i * 8'h11));
    pulse_end();
    vectors++; if (word_count !== 3'd1 || load_err !== 1'b1 || load_done !== 1'b1) begin
      miscompares++; $display("[TB] FAIL partial_status: got wc=%0d er=%b dn=%b, want 1 1 1", word_count, load_err, load_done); end
    do_read(32'h0);
    vectors++; if (instruction !== 32'h44332211) begin
      miscompares++; $display("[TB] FAIL partial_word0: got %h, want 44332211", instruction); end
    do_read(32'h4);
    vectors++; if (instruction !== 32'h0) begin
      miscompares++; $display("[TB] FAIL partial_read_0x4: got %h, want 00000000", instruction); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_words [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    pulse_start();
    for (int i = 0; i < 17; i++) send_byte(8'(8'h10 + i));
    vectors++; if (word_count !== 3'd4 || load_err !== 1'b1 || loading !== 1'b1) begin
      miscompares++; $display("[TB] FAIL overflow_status: got wc=%0d er=%b ld=%b, want 4 1 1", word_count, load_err, loading); end
    pulse_end();
    vectors++; if (load_err !== 1'b1 || load_done !== 1'b1) begin
      miscompares++; $display("[TB] FAIL overflow_sticky: got er=%b dn=%b, want 1 1", load_err, load_done); end
    for (int w = 0; w < 4; w++) begin
      do_read(32'(w * 4 + 3));
      vectors++; if (instruction !== exp_words[w]) begin
        miscompares++; $display("[TB] FAIL overflow_word%0d: got %h, want %h", w, instruction, exp_words[w]); end
    end
    do_read(32'h10);
    vectors++; if (instruction !== 32'h0) begin
      miscompares++; $display("[TB] FAIL beyond_depth: got %h, want 00000000", instruction); end
  endtask

  task automatic test_coincident_end();
    pulse_start();
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD);
    rx_valid = 1'b1; rx_byte = 8'hDE; load_end = 1'b1;
    cycle();
    rx_valid = 1'b0; load_end = 1'b0;
    vectors++; if (word_count !== 3'd1 || load_err !== 1'b0 || load_done !== 1'b1) begin
      miscompares++; $display("[TB] FAIL coincident_status: got wc=%0d er=%b dn=%b, want 1 0 1", word_count, load_err, load_done); end
    do_read(32'h2);
    vectors++; if (instruction !== 32'hDEADBEEF) begin
      miscompares++; $display("[TB] FAIL coincident_word: got %h, want deadbeef", instruction); end
  endtask

  task automatic test_read_during_load();
    logic [7:0] bytes [8] = '{8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hB4, 8'hB3, 8'hB2, 8'hB1};
    int bad = 0;
    pulse_start();
    rd_en = 1'b1; rd_addr = 32'h0;
    foreach (bytes[i]) begin
      rx_valid = 1'b1; rx_byte = bytes[i];
      cycle();
      vectors++; if (instruction !== 32'h0 || rd_valid !== 1'b1) begin
        miscompares++; bad++; $display("[TB] FAIL load_read_nop%0d: got %h rv=%b, want 00000000 rv=1", i, instruction, rd_valid); end
    end
    rx_valid = 1'b0; rd_en = 1'b0;
    pulse_end();
    send_byte(8'h55);
    vectors++; if (word_count !== 3'd2 || load_done !== 1'b1) begin
      miscompares++; $display("[TB] FAIL rx_outside_load: got wc=%0d dn=%b, want 2 1", word_count, load_done); end
    pulse_start();
    vectors++; if (word_count !== 3'd0 || loading !== 1'b1 || load_done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL start_in_done: got wc=%0d ld=%b dn=%b, want 0 1 0", word_count, loading, load_done); end
    send_byte(8'h01); send_byte(8'h02);
    start = 1'b1; load_end = 1'b1;
    cycle();
    start = 1'b0; load_end = 1'b0;
    vectors++; if (loading !== 1'b1 || load_err !== 1'b0) begin
      miscompares++; $display("[TB] FAIL start_over_end: got ld=%b er=%b, want 1 0", loading, load_err); end
    pulse_end();
    vectors++; if (load_done !== 1'b1 || load_err !== 1'b0 || word_count !== 3'd0) begin
      miscompares++; $display("[TB] FAIL lane_cleared: got dn=%b er=%b wc=%0d, want 1 0 0", load_done, load_err, word_count); end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    for (int i = 1; i <= 12; i++) send_byte(8'(i));
    pulse_end();
    do_read(32'h8);
    vectors++; if (instruction !== 32'h0C0B0A09) begin
      miscompares++; $display("[TB] FAIL preload_word2: got %h, want 0c0b0a09", instruction); end
    pulse_start();
    for (int i = 1; i <= 12; i++) send_byte(8'(8'h80 + i));
    vectors++; if (word_count !== 3'd3 || loading !== 1'b1) begin
      miscompares++; $display("[TB] FAIL mid_load_count: got wc=%0d ld=%b, want 3 1", word_count, loading); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (instruction !== 32'h0 || rd_valid !== 1'b0 || loading !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0 || word_count !== 3'd0) begin
      miscompares++; $display("[TB] FAIL async_reset: got ins=%h rv=%b ld=%b dn=%b er=%b wc=%0d, want 0 0 0 0 0 0", instruction, rd_valid, loading, load_done, load_err, word_count); end
    #2 rst_n = 1'b1;
    cycle();
    do_read(32'h4);
    vectors++; if (instruction !== 32'h0 || rd_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL post_reset_read: got %h rv=%b, want 00000000 rv=1", instruction, rd_valid); end
  endtask

  initial begin
    $display("[TB] starting prog_mem_loader bench");
    test_reset();
    test_load_two();
    test_partial();
    test_overflow();
    test_coincident_end();
    test_read_during_load();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
